// File: rtl/param_pattern_detect.sv
// Serial pattern detector: hunts for PAT_W-bit pattern, then tracks it word-aligned,
// locking after REPEAT_N aligned matches and unlocking after LOSS_N aligned misses.
module param_pattern_detect #(
  parameter int PAT_W    = 16,
  parameter int REPEAT_N = 2,
  parameter int LOSS_N   = 2,
  parameter int CNT_W    = 16,
  parameter int STICKY   = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             data_valid,
  input  logic             data,
  input  logic [PAT_W-1:0] pattern,
  input  logic             clear,
  output logic             locked,
  output logic             match_pulse,
  output logic [CNT_W-1:0] match_count,
  output logic [1:0]       state,
  output logic [3:0]       DONE_VALUE
);

  localparam logic [1:0] ST_SEARCH = 2'b00;
  localparam logic [1:0] ST_TRACK  = 2'b01;
  localparam logic [1:0] ST_LOCKED = 2'b10;

  localparam int FILL_W = $clog2(PAT_W + 1);
  localparam int BIT_W  = $clog2(PAT_W);

  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);
  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(PAT_W - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(PAT_W - 1);
  localparam logic [7:0]        REP_TGT   = 8'(REPEAT_N);
  localparam logic [7:0]        LOSS_TGT  = 8'(LOSS_N);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

  localparam logic [3:0] DONE_LOCKED = 4'b0101;
  localparam logic [3:0] DONE_IDLE   = 4'b1010;

  // The oldest bit of the PAT_W-bit window is never compared again, so only
  // the younger PAT_W-1 bits are stored; the candidate appends the live bit.
  logic [PAT_W-2:0]  r_sr;
  logic [FILL_W-1:0] r_fill;
  logic [BIT_W-1:0]  r_bit;
  logic [7:0]        r_rep;
  logic [7:0]        r_loss;
  logic [1:0]        r_state;
  logic              r_locked;
  logic              r_pulse;
  logic [CNT_W-1:0]  r_count;
  logic [3:0]        r_done;

  logic [PAT_W-1:0]  w_cand;
  logic              w_hit;
  logic              w_fill_ok;
  logic              w_aligned;
  logic              w_accept;
  logic [1:0]        w_state_nx;
  logic [7:0]        w_rep_nx;
  logic [7:0]        w_loss_nx;
  logic [BIT_W-1:0]  w_bit_nx;

  assign w_cand    = {r_sr, data};
  assign w_hit     = (w_cand == pattern);
  assign w_fill_ok = (r_fill >= FILL_LAST);
  assign w_aligned = (r_bit == BIT_LAST);

  always_comb begin
    w_state_nx = r_state;
    w_rep_nx   = r_rep;
    w_loss_nx  = r_loss;
    w_bit_nx   = r_bit;
    w_accept   = 1'b0;
    if (data_valid) begin
      w_bit_nx = w_aligned ? '0 : r_bit + 1'b1;
      case (r_state)
        ST_SEARCH: begin
          if (w_hit && w_fill_ok) begin
            w_accept   = 1'b1;
            w_rep_nx   = 8'd1;
            w_loss_nx  = 8'd0;
            w_bit_nx   = '0;
            w_state_nx = (REPEAT_N == 1) ? ST_LOCKED : ST_TRACK;
          end
        end
        ST_TRACK: begin
          if (w_aligned) begin
            if (w_hit) begin
              w_accept = 1'b1;
              w_rep_nx = r_rep + 8'd1;
              if (w_rep_nx == REP_TGT) begin
                w_state_nx = ST_LOCKED;
                w_loss_nx  = 8'd0;
              end
            end else begin
              w_state_nx = ST_SEARCH;
              w_rep_nx   = 8'd0;
            end
          end
        end
        ST_LOCKED: begin
          if (w_aligned) begin
            if (w_hit) begin
              w_accept  = 1'b1;
              w_loss_nx = 8'd0;
            end else begin
              // Loss count saturates at LOSS_N so a sticky lock cannot wrap it.
              w_loss_nx = (r_loss == LOSS_TGT) ? r_loss : r_loss + 8'd1;
              if (STICKY == 0 && w_loss_nx == LOSS_TGT) begin
                w_state_nx = ST_SEARCH;
                w_rep_nx   = 8'd0;
                w_loss_nx  = 8'd0;
              end
            end
          end
        end
        default: begin
          w_state_nx = ST_SEARCH;
          w_rep_nx   = 8'd0;
          w_loss_nx  = 8'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst || clear) begin
      r_sr     <= '0;
      r_fill   <= '0;
      r_bit    <= '0;
      r_rep    <= 8'd0;
      r_loss   <= 8'd0;
      r_state  <= ST_SEARCH;
      r_locked <= 1'b0;
      r_pulse  <= 1'b0;
      r_count  <= '0;
      r_done   <= DONE_IDLE;
    end else begin
      if (data_valid) begin
        r_sr <= w_cand[PAT_W-2:0];
        if (r_fill != FILL_FULL) r_fill <= r_fill + 1'b1;
      end
      r_bit    <= w_bit_nx;
      r_rep    <= w_rep_nx;
      r_loss   <= w_loss_nx;
      r_state  <= w_state_nx;
      r_pulse  <= w_accept;
      r_locked <= (w_state_nx == ST_LOCKED);
      r_done   <= (w_state_nx == ST_LOCKED) ? DONE_LOCKED : DONE_IDLE;
      if (w_accept && r_count != CNT_MAX) r_count <= r_count + 1'b1;
    end
  end

  assign locked      = r_locked;
  assign match_pulse = r_pulse;
  assign match_count = r_count;
  assign state       = r_state;
  assign DONE_VALUE  = r_done;

endmodule

// File: tb/tb_param_pattern_detect.sv
// Bench for param_pattern_detect: a non-sticky and a sticky/narrow-count instance share
// one randomized stream and are checked every cycle against a bit-history reference model.
module tb_param_pattern_detect;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        data_valid = 1'b0;
  logic        data = 1'b0;
  logic [15:0] pattern = 16'hABCD;
  logic        clear = 1'b0;

  logic        locked_a, pulse_a, locked_s, pulse_s;
  logic [15:0] count_a;
  logic [2:0]  count_s;
  logic [1:0]  state_a, state_s;
  logic [3:0]  done_a, done_s;

  int checks = 0;
  int failures = 0;
  bit started = 1'b0;

  param_pattern_detect #(.PAT_W(16), .REPEAT_N(2), .LOSS_N(2), .CNT_W(16), .STICKY(0)) dut (
    .clk(clk), .rst(rst), .data_valid(data_valid), .data(data), .pattern(pattern),
    .clear(clear), .locked(locked_a), .match_pulse(pulse_a), .match_count(count_a),
    .state(state_a), .DONE_VALUE(done_a));

  param_pattern_detect #(.PAT_W(16), .REPEAT_N(2), .LOSS_N(2), .CNT_W(3), .STICKY(1)) dut_s (
    .clk(clk), .rst(rst), .data_valid(data_valid), .data(data), .pattern(pattern),
    .clear(clear), .locked(locked_s), .match_pulse(pulse_s), .match_count(count_s),
    .state(state_s), .DONE_VALUE(done_s));

  // clock / reset block
  always #5 clk = ~clk;

  // reference model: n counts valid bits since restart, anchor is the bit index of the
  // search hit, so aligned comparisons fall on bits where (n - anchor) is a multiple of 16
  typedef struct {
    int          n;
    logic [15:0] win;
    int          mode;
    int          anchor;
    int          reps;
    int          losses;
    int          count;
    bit          pulse;
  } mdl_t;

  mdl_t ma, ms;

  function automatic mdl_t mdl_reset();
    mdl_t m;
    m.n = 0; m.win = 16'h0; m.mode = 0; m.anchor = 0;
    m.reps = 0; m.losses = 0; m.count = 0; m.pulse = 1'b0;
    return m;
  endfunction

  function automatic mdl_t mdl_step(mdl_t m, bit sticky, int cmax, bit r, bit c,
                                    bit dv, bit d, logic [15:0] pat);
    bit accept;
    bit eq;
    if (!r || c) return mdl_reset();
    m.pulse = 1'b0;
    if (!dv) return m;
    accept = 1'b0;
    m.n = m.n + 1;
    m.win = {m.win[14:0], d};
    eq = (m.win == pat);
    if (m.mode == 0) begin
      if (eq && m.n >= 16) begin
        accept = 1'b1; m.anchor = m.n; m.reps = 1; m.losses = 0; m.mode = 1;
      end
    end else if (((m.n - m.anchor) % 16) == 0) begin
      if (m.mode == 1) begin
        if (eq) begin
          accept = 1'b1; m.reps++;
          if (m.reps >= 2) begin m.mode = 2; m.losses = 0; end
        end else begin
          m.mode = 0; m.reps = 0;
        end
      end else begin
        if (eq) begin
          accept = 1'b1; m.losses = 0;
        end else begin
          m.losses++;
          if (m.losses >= 2 && !sticky) begin m.mode = 0; m.reps = 0; m.losses = 0; end
        end
      end
    end
    if (accept) begin
      m.pulse = 1'b1;
      if (m.count < cmax) m.count++;
    end
    return m;
  endfunction

  always @(posedge clk) begin
    ma = mdl_step(ma, 1'b0, 65535, rst, clear, data_valid, data, pattern);
    ms = mdl_step(ms, 1'b1, 7, rst, clear, data_valid, data, pattern);
    started = 1'b1;
  end

  // scoreboard helpers
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%h exp=%h", name, $time, got, exp);
    end
  endtask

  function automatic logic [3:0] exp_done(int mode);
    return (mode == 2) ? 4'b0101 : 4'b1010;
  endfunction

  // per-cycle compare process
  always @(negedge clk) begin
    if (started) begin
      chk("a.locked", {31'b0, locked_a}, (ma.mode == 2) ? 32'd1 : 32'd0);
      chk("a.state",  {30'b0, state_a},  32'(ma.mode));
      chk("a.pulse",  {31'b0, pulse_a},  {31'b0, ma.pulse});
      chk("a.count",  {16'b0, count_a},  32'(ma.count));
      chk("a.done",   {28'b0, done_a},   {28'b0, exp_done(ma.mode)});
      chk("s.locked", {31'b0, locked_s}, (ms.mode == 2) ? 32'd1 : 32'd0);
      chk("s.state",  {30'b0, state_s},  32'(ms.mode));
      chk("s.pulse",  {31'b0, pulse_s},  {31'b0, ms.pulse});
      chk("s.count",  {29'b0, count_s},  32'(ms.count));
      chk("s.done",   {28'b0, done_s},   {28'b0, exp_done(ms.mode)});
    end
  end

  // driver tasks: inputs change on the falling edge, outputs are read on the next one
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int cycles);
    data_valid = 1'b0;
    for (int i = 0; i < cycles; i++) tick();
  endtask

  task automatic send_bit(input bit d, input bit gaps);
    if (gaps) idle($urandom_range(0, 2));
    data = d;
    data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
  endtask

  task automatic send_word(input logic [15:0] w, input bit gaps);
    for (int i = 15; i >= 0; i--) send_bit(w[i], gaps);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  initial begin
    logic [15:0] w;
    int r;
    ma = mdl_reset();
    ms = mdl_reset();
    @(negedge clk);
    idle(3);
    rst = 1'b1;
    idle(2);
    chk("reset.locked", {31'b0, locked_a}, 32'd0);
    chk("reset.state",  {30'b0, state_a},  32'd0);
    chk("reset.count",  {16'b0, count_a},  32'd0);
    chk("reset.done",   {28'b0, done_a},   32'h0000000A);

    // ABCD ABCD back-to-back locks after the second word
    w = 16'hABCD;
    for (int i = 15; i >= 0; i--) send_bit(w[i], 1'b0);
    chk("abcd1.pulse", {31'b0, pulse_a}, 32'd1);
    chk("abcd1.state", {30'b0, state_a}, 32'd1);
    send_word(16'hABCD, 1'b0);
    chk("abcd2.pulse",  {31'b0, pulse_a}, 32'd1);
    chk("abcd2.locked", {31'b0, locked_a}, 32'd1);
    chk("abcd2.done",   {28'b0, done_a},  32'h00000005);
    chk("abcd2.count",  {16'b0, count_a}, 32'd2);

    // loss sequence: one bad word keeps lock, the second drops it unless sticky
    send_word(16'h0000, 1'b0);
    chk("loss1.locked", {31'b0, locked_a}, 32'd1);
    send_word(16'hABCD, 1'b0);
    send_word(16'h0000, 1'b0);
    chk("loss2a.locked", {31'b0, locked_a}, 32'd1);
    send_word(16'h0000, 1'b0);
    chk("loss3.state",   {30'b0, state_a},  32'd0);
    chk("loss3.locked",  {31'b0, locked_a}, 32'd0);
    chk("sticky.locked", {31'b0, locked_s}, 32'd1);

    // ABCD then 1234 tracks then falls back to search
    do_clear();
    send_word(16'hABCD, 1'b0);
    chk("trk.state", {30'b0, state_a}, 32'd1);
    send_word(16'h1234, 1'b0);
    chk("trk.back",   {30'b0, state_a},  32'd0);
    chk("trk.locked", {31'b0, locked_a}, 32'd0);

    // clear on the completing bit wins
    do_clear();
    for (int i = 15; i >= 1; i--) send_bit(w[i], 1'b0);
    clear = 1'b1;
    send_bit(w[0], 1'b0);
    clear = 1'b0;
    chk("clr.pulse", {31'b0, pulse_a}, 32'd0);
    chk("clr.state", {30'b0, state_a}, 32'd0);
    chk("clr.count", {16'b0, count_a}, 32'd0);

    // all-zero pattern needs a full fill before the first hit, with gaps
    pattern = 16'h0000;
    do_clear();
    for (int i = 0; i < 15; i++) send_bit(1'b0, 1'b1);
    chk("zero15.count", {16'b0, count_a}, 32'd0);
    send_bit(1'b0, 1'b1);
    chk("zero16.pulse", {31'b0, pulse_a}, 32'd1);
    chk("zero16.count", {16'b0, count_a}, 32'd1);
    for (int i = 0; i < 16; i++) send_bit(1'b0, 1'b1);
    chk("zero32.locked", {31'b0, locked_a}, 32'd1);

    // reset while locked with clear and data_valid asserted
    rst = 1'b0; clear = 1'b1; data_valid = 1'b1;
    tick();
    rst = 1'b1; clear = 1'b0; data_valid = 1'b0;
    chk("rstlock.locked", {31'b0, locked_a}, 32'd0);
    chk("rstlock.done",   {28'b0, done_a},   32'h0000000A);

    // randomized stream with pattern bursts, occasional clear and reset
    pattern = 16'hABCD;
    do_clear();
    for (int k = 0; k < 600; k++) begin
      r = $urandom_range(0, 99);
      if (r < 35) send_word(16'hABCD, $urandom_range(0, 1) == 1);
      else if (r < 40) send_word(16'($urandom), 1'b1);
      else if (r < 42) do_clear();
      else if (r < 43) begin rst = 1'b0; tick(); rst = 1'b1; end
      else begin
        data = 1'($urandom_range(0, 1));
        data_valid = ($urandom_range(0, 3) != 0);
        clear = ($urandom_range(0, 199) == 0);
        tick();
        data_valid = 1'b0;
        clear = 1'b0;
      end
    end
    idle(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/param_pattern_detect.md
PARAM_PATTERN_DETECT -- requirements
Module: param_pattern_detect

Interface
REQ-001 SHALL provide parameter PAT_W, default 16, pattern length in bits, legal range 2..64.
REQ-002 SHALL provide parameter REPEAT_N, default 2, number of consecutive aligned matches required for lock, legal range 1..255.
REQ-003 SHALL provide parameter LOSS_N, default 2, number of consecutive aligned mismatches that drop lock, legal range 1..255.
REQ-004 SHALL provide parameter CNT_W, default 16, width of match_count.
REQ-005 SHALL provide parameter STICKY, default 0; when 1, LOCKED is held until clear or reset.
REQ-006 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-007 SHALL have ports: rst  in  1  synchronous active-low reset.
REQ-008 SHALL have ports: data_valid  in  1  qualifies data on the current edge.
REQ-009 SHALL have ports: data  in  1  serial bit, first transmitted bit is the pattern MSB.
REQ-010 SHALL have ports: pattern  in  PAT_W  target pattern, static while detection is active.
REQ-011 SHALL have ports: clear  in  1  synchronous restart to SEARCH.
REQ-012 SHALL have ports: locked  out  1  high in LOCKED.
REQ-013 SHALL have ports: match_pulse  out  1  one-cycle pulse per accepted match.
REQ-014 SHALL have ports: match_count  out  CNT_W  saturating count of accepted matches.
REQ-015 SHALL have ports: state  out  2  SEARCH=00, TRACK=01, LOCKED=10.
REQ-016 SHALL have ports: DONE_VALUE  out  4  4'b0101 when locked, else 4'b1010.

Function
REQ-017 SHALL shift data into a PAT_W-bit register, new bit into the LSB, only on edges with data_valid=1; the candidate word is {sr[PAT_W-2:0],data}.
REQ-018 SHALL maintain a fill counter; no match is accepted until PAT_W valid bits have been shifted in since reset or clear, including the completing bit.
REQ-019 SHALL maintain a bit counter, 0..PAT_W-1, of valid bits since the last alignment point; it wraps to 0 after PAT_W-1.
REQ-020 In SEARCH, SHALL accept a match on any valid bit where the candidate equals pattern and the fill condition holds.
REQ-021 An accepted match in SEARCH SHALL set the repeat count to 1, set the bit counter to 0, and enter TRACK; if REPEAT_N=1, it SHALL enter LOCKED directly.
REQ-022 In TRACK and LOCKED, SHALL compare only on the valid bit where the bit counter equals PAT_W-1, i.e. the alignment point; unaligned bits are not compared.
REQ-023 In TRACK, an aligned match SHALL increment the repeat count and enter LOCKED when the count reaches REPEAT_N; an aligned mismatch SHALL return to SEARCH with the repeat count at 0.
REQ-024 In LOCKED, an aligned match SHALL clear the loss count; an aligned mismatch SHALL increment it, and reaching LOSS_N SHALL return to SEARCH, unless STICKY=1.
REQ-025 match_pulse SHALL be high for exactly the one cycle following the edge that accepted a match.
REQ-026 match_count SHALL increment on every accepted match and saturate at all-ones without wrapping.
REQ-027 locked and DONE_VALUE SHALL be registered and SHALL change on the cycle after the state transition edge.
REQ-028 When data_valid=0, no state, counter, or shift register SHALL change, except under clear.
REQ-029 clear SHALL take priority over a simultaneously completing bit: there is no match pulse, state becomes SEARCH, and the shift, fill, bit, repeat, and loss counters clear; match_count SHALL be cleared as well.
REQ-030 A pattern change without clear SHALL be undefined in effect.

Reset
REQ-031 When rst=0 on a rising edge, the block SHALL clear the shift register, all counters, and match_count.
REQ-032 When rst=0 on a rising edge, the block SHALL set state=SEARCH, locked=0, match_pulse=0, and DONE_VALUE=4'b1010.
REQ-033 Reset SHALL override clear and data_valid, including mid-pattern and while LOCKED.

Verification
REQ-034 Reset, then idle -> locked=0, state=00, match_count=0, DONE_VALUE=1010.
REQ-035 PAT_W=16, pattern=16'hABCD, REPEAT_N=2, stream ABCD ABCD back-to-back -> match_pulse after bits 16 and 32, locked=1 and DONE_VALUE=0101 the cycle after bit 32, match_count=2.
REQ-036 Same setup, stream ABCD 1234 -> state TRACK after bit 16, SEARCH after bit 32, locked never 1.
REQ-037 Locked with LOSS_N=2, send 0000 ABCD 0000 0000 -> lock kept after 1 bad word, lost after the 2nd consecutive bad word, state=00; with STICKY=1, lock held.
REQ-038 pattern=16'h0000, zeros from reset -> first match_pulse only after the 16th valid zero; the same stream with random data_valid gaps yields identical pulse ordering.
REQ-039 clear asserted on the edge of the 16th matching bit -> no match_pulse, state=00, match_count=0.
